flopr: RTL and testbench



---
 rtl/flopr.sv | 34 +++
 tb/tb_flopr.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/flopr.sv
// flopr: parameterizable-width D register with asynchronous active-high reset.
//
// Basic storage element of the datapath. Pipeline registers, the PC register
// and other state elements are built from it. It captures d on every rising
// edge of clk. It has no enable and no other control.
//
// Parameters:
//   WIDTH  bit width of d and q (>= 1). Default 64; the 32-bit instance is WIDTH=32.
//
// Ports (in positional order):
//   clk    input               system clock, rising edge active
//   reset  input               asynchronous, active-high; clears q to all zeros at once
//   d      input  [WIDTH-1:0]  data to capture
//   q      output [WIDTH-1:0]  registered data, one cycle after d
module flopr #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset sits in the sensitivity list, so the clear does not wait for clk.
  // When reset is high at a clock edge, it also wins over the capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: tb/tb_flopr.sv
// tb_flopr: self-checking bench for flopr.
// Runs a 32-bit instance and a default (64-bit) instance side by side.
// Inputs change on falling edges. Outputs are sampled 1ns after rising edges.
// Expected values go into a scoreboard queue when stimulus is driven. They are
// popped and compared when the capturing edge has passed.
module tb_flopr;

  // ---------------------------------------------------------------- clock/reset
  logic        clk;
  logic        reset;
  logic [31:0] d32;
  logic [31:0] q32;
  logic [63:0] d64;
  logic [63:0] q64;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  flopr #(.WIDTH(32)) dut32 (
    .clk   (clk),
    .reset (reset),
    .d     (d32),
    .q     (q32)
  );

  flopr dut64 (
    .clk   (clk),
    .reset (reset),
    .d     (d64),
    .q     (q64)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [31:0] exp_q32[$];
  logic [63:0] exp_q64[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] actual,
                          input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // One clock cycle of stimulus. Drive on the falling edge and queue the
  // expected output. Then compare just after the following rising edge.
  task automatic drive_cycle(input string tag, input logic rst,
                             input logic [31:0] v32, input logic [63:0] v64);
    logic [31:0] e32;
    logic [63:0] e64;
    @(negedge clk);
    reset = rst;
    d32   = v32;
    d64   = v64;
    exp_q32.push_back(rst ? 32'h0 : v32);
    exp_q64.push_back(rst ? 64'h0 : v64);
    @(posedge clk);
    #1;
    if (exp_q32.size() == 0 || exp_q64.size() == 0) begin
      check_eq({tag, "_empty_q"}, 64'd1, 64'd0);
    end else begin
      e32 = exp_q32.pop_front();
      e64 = exp_q64.pop_front();
      check_eq({tag, "_q32"}, {32'h0, q32}, {32'h0, e32});
      check_eq({tag, "_q64"}, q64, e64);
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [31:0] seq_vec [10];

  initial begin
    seq_vec = '{32'h2A3BCD4E, 32'h5E7F8A9B, 32'hA1B2C3D4, 32'h9ABCDEF0,
                32'hFEDCBA98, 32'h12345678, 32'hCAFEBABE, 32'hBADC0FFE,
                32'h00000000, 32'hFFFFFFFF};
  end

  initial begin
    logic [63:0] r64;
    reset = 1'b1;
    d32   = 32'h2A3BCD4E;
    d64   = 64'hDEADBEEF_01234567;

    // Reset held for 5 cycles with live data on d: q must stay zero.
    for (int i = 0; i < 5; i++)
      drive_cycle("reset_hold", 1'b1, 32'h2A3BCD4E, 64'hDEADBEEF_01234567);

    // Release reset on a falling edge and load the first vector on the next rising edge.
    drive_cycle("w64_first", 1'b0, 32'h2A3BCD4E, 64'hDEADBEEF_01234567);

    // Sequential capture. The sequence includes the 0 -> all-ones extreme
    // and the CAFEBABE/BADC0FFE stuck-bit patterns.
    for (int i = 0; i < 10; i++) begin
      r64 = {$urandom(), $urandom()};
      drive_cycle("seq", 1'b0, seq_vec[i], r64);
    end

    // Load 12345678 and then pulse reset for 2ns between edges.
    drive_cycle("pre_async", 1'b0, 32'h12345678, 64'h0123_4567_89AB_CDEF);
    #1 reset = 1'b1;
    #1;
    check_eq("async_clr_q32", {32'h0, q32}, 64'h0);
    check_eq("async_clr_q64", q64, 64'h0);
    #1 reset = 1'b0;
    #1;
    check_eq("async_after_release_q32", {32'h0, q32}, 64'h0);
    drive_cycle("post_async", 1'b0, 32'hCAFEBABE, 64'hFFFF_FFFF_FFFF_FFFF);

    // Hold: d stays constant for 3 cycles. A change to d between edges
    // must not reach q.
    for (int i = 0; i < 3; i++) begin
      drive_cycle("hold", 1'b0, 32'hBADC0FFE, 64'hBADC0FFE_BADC0FFE);
      #1;
      d32 = 32'h5555AAAA;
      d64 = 64'h5555AAAA_5555AAAA;
      #1;
      check_eq("hold_mid_q32", {32'h0, q32}, {32'h0, 32'hBADC0FFE});
      check_eq("hold_mid_q64", q64, 64'hBADC0FFE_BADC0FFE);
    end

    // Random traffic.
    for (int i = 0; i < 20; i++) begin
      r64 = {$urandom(), $urandom()};
      drive_cycle("rand", 1'b0, $urandom(), r64);
    end

    // Synchronous-looking reset: reset high across an edge must give zero.
    drive_cycle("reset_at_edge", 1'b1, 32'hFFFFFFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    drive_cycle("after_reset", 1'b0, 32'h0F0F0F0F, 64'hF0F0F0F0_0F0F0F0F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
